// File: rtl/snake_frame_builder.sv
// snake_frame_builder: rebuilds the 8x16 LED frame from the body FIFO (pop + write-back), overlays food, scans rows to the matrix
module snake_frame_builder #(
  parameter int SCAN_DIV = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_req,
  input  logic [7:0]  fifo_q,
  input  logic        fifo_empty,
  input  logic [3:0]  fifo_usedw,
  output logic        fifo_rdreq,
  output logic        fifo_wrreq,
  output logic [7:0]  fifo_data,
  input  logic [3:0]  food_x,
  input  logic [3:0]  food_y,
  output logic        busy,
  output logic        frame_done,
  output logic        collision,
  output logic [2:0]  scan_row,
  output logic [15:0] scan_data
);
  typedef enum logic [2:0] {IDLE, CLEAR, READ, OVERLAY, COMMIT} state_t;
  state_t      state_q;
  logic [15:0] work_q [8];
  logic [15:0] disp_q [8];
  logic [2:0]  row_q;
  logic [4:0]  rem_q;
  logic        pend_q;
  logic        busy_q;
  logic        done_q;
  logic        coll_q;
  logic [31:0] div_q;
  logic [2:0]  scan_row_q;
  logic        rd_req;
  logic [3:0]  px;
  logic [3:0]  py;
  assign rd_req     = state_q == READ && rem_q != 5'd0 && !fifo_empty;
  assign px         = fifo_q[7:4];
  assign py         = fifo_q[3:0];
  assign fifo_rdreq = rd_req;
  assign fifo_wrreq = pend_q;
  assign fifo_data  = pend_q ? fifo_q : 8'd0;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign collision  = coll_q;
  assign scan_row   = scan_row_q;
  assign scan_data  = disp_q[scan_row_q];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      row_q      <= 3'd0;
      rem_q      <= 5'd0;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      coll_q     <= 1'b0;
      div_q      <= 32'd0;
      scan_row_q <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        work_q[i] <= 16'd0;
        disp_q[i] <= 16'd0;
      end
    end else begin
      done_q <= 1'b0;
      pend_q <= rd_req;
      div_q  <= div_q == 32'(SCAN_DIV - 1) ? 32'd0 : div_q + 32'd1;
      if (div_q == 32'(SCAN_DIV - 1)) scan_row_q <= scan_row_q + 3'd1;
      case (state_q)
        IDLE: if (frame_req) begin
          state_q <= CLEAR;
          busy_q  <= 1'b1;
        end
        CLEAR: begin
          work_q[row_q] <= 16'd0;
          // usedw wraps to 0 when the 16-deep FIFO is full
          rem_q  <= (fifo_usedw == 4'd0 && !fifo_empty) ? 5'd16 : {1'b0, fifo_usedw};
          coll_q <= 1'b0;
          row_q  <= row_q + 3'd1;
          if (row_q == 3'd7) state_q <= READ;
        end
        READ: begin
          if (rd_req) rem_q <= rem_q - 5'd1;
          if (pend_q && !py[3]) begin
            if (work_q[py[2:0]][px]) coll_q <= 1'b1;
            work_q[py[2:0]][px] <= 1'b1;
          end
          // the cycle with no new pop still retires the last outstanding entry
          if (!rd_req) state_q <= OVERLAY;
        end
        OVERLAY: begin
          if (!food_y[3]) work_q[food_y[2:0]][food_x] <= 1'b1;
          state_q <= COMMIT;
        end
        COMMIT: begin
          for (int i = 0; i < 8; i++) disp_q[i] <= work_q[i];
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_snake_frame_builder.sv
// tb_snake_frame_builder: directed frames against a FIFO model and a spec-level display model
module tb_snake_frame_builder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_req = 1'b0;
  logic [7:0]  fifo_q = 8'd0;
  logic        fifo_empty = 1'b1;
  logic [3:0]  fifo_usedw = 4'd0;
  logic        fifo_rdreq;
  logic        fifo_wrreq;
  logic [7:0]  fifo_data;
  logic [3:0]  food_x = 4'd0;
  logic [3:0]  food_y = 4'd8;
  logic        busy;
  logic        frame_done;
  logic        collision;
  logic [2:0]  scan_row;
  logic [15:0] scan_data;
  always #5 clk = ~clk;
  snake_frame_builder #(.SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .frame_req(frame_req), .fifo_q(fifo_q),
    .fifo_empty(fifo_empty), .fifo_usedw(fifo_usedw), .fifo_rdreq(fifo_rdreq),
    .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data), .food_x(food_x), .food_y(food_y),
    .busy(busy), .frame_done(frame_done), .collision(collision),
    .scan_row(scan_row), .scan_data(scan_data)
  );
  int checks = 0;
  int errors = 0;
  logic [7:0]  fq [$];
  logic        ld_en = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  ld_data = 8'd0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int n_edges = 0;
  logic        cmp_en = 1'b0;
  logic        m_busy = 1'b0;
  logic [15:0] m_disp [8];
  logic [15:0] e_disp [8];
  logic        e_coll;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fq.delete();
      fifo_q     <= 8'd0;
      fifo_empty <= 1'b1;
      fifo_usedw <= 4'd0;
      n_edges    <= 0;
    end else begin
      n_edges <= n_edges + 1;
      if (flush) fq.delete();
      if (fifo_rdreq) begin
        fifo_q <= fq.size() != 0 ? fq[0] : 8'hEE;
        if (fq.size() != 0) void'(fq.pop_front());
        rd_cnt <= rd_cnt + 1;
      end
      if (fifo_wrreq) begin
        fq.push_back(fifo_data);
        wr_cnt <= wr_cnt + 1;
      end
      if (ld_en) fq.push_back(ld_data);
      if (frame_done) done_cnt <= done_cnt + 1;
      fifo_empty <= fq.size() == 0;
      fifo_usedw <= 4'(fq.size());
    end
  end
  always @(negedge clk) begin
    if (!reset && cmp_en) begin
      chk("scan_row", 32'(scan_row), 32'((n_edges / 4) % 8));
      chk("scan_data", 32'(scan_data), 32'(m_disp[(n_edges / 4) % 8]));
      chk("busy", 32'(busy), 32'(m_busy));
      if (!m_busy) begin
        chk("rdreq_idle", 32'(fifo_rdreq), 32'd0);
        chk("wrreq_idle", 32'(fifo_wrreq), 32'd0);
      end
    end
  end
  task automatic build(input logic [7:0] b [$], input logic [3:0] fx, input logic [3:0] fy);
    for (int i = 0; i < 8; i++) e_disp[i] = 16'd0;
    e_coll = 1'b0;
    foreach (b[i]) begin
      if (b[i][3:0] < 4'd8) begin
        if (e_disp[b[i][2:0]][b[i][7:4]]) e_coll = 1'b1;
        e_disp[b[i][2:0]][b[i][7:4]] = 1'b1;
      end
    end
    if (fy < 4'd8) e_disp[fy[2:0]][fx] = 1'b1;
  endtask
  task automatic load(input logic [7:0] b [$], input logic [3:0] fx, input logic [3:0] fy);
    @(negedge clk) flush = 1'b1;
    @(negedge clk) flush = 1'b0;
    foreach (b[i]) begin
      ld_en = 1'b1;
      ld_data = b[i];
      @(negedge clk);
    end
    ld_en = 1'b0;
    food_x = fx;
    food_y = fy;
    @(negedge clk);
  endtask
  task automatic run_frame(input string tag, input logic [7:0] b [$], input logic [3:0] fx,
                           input logic [3:0] fy, input bit spam);
    int n;
    int lat;
    int r0;
    int w0;
    int d0;
    load(b, fx, fy);
    build(b, fx, fy);
    n = b.size();
    lat = 8 + n + 3;
    r0 = rd_cnt;
    w0 = wr_cnt;
    d0 = done_cnt;
    frame_req = 1'b1;
    @(posedge clk) m_busy = 1'b1;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk) frame_req = spam && (i % 2 == 0) && i < 8;
      @(posedge clk);
    end
    m_busy = 1'b0;
    for (int i = 0; i < 8; i++) m_disp[i] = e_disp[i];
    @(negedge clk);
    chk({tag, "_done_at_latency"}, 32'(frame_done), 32'd1);
    chk({tag, "_collision"}, 32'(collision), 32'(e_coll));
    @(negedge clk);
    chk({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_rdreq_cnt"}, 32'(rd_cnt - r0), 32'(n));
    chk({tag, "_wrreq_cnt"}, 32'(wr_cnt - w0), 32'(n));
    chk({tag, "_fifo_len"}, 32'(fq.size()), 32'(n));
    for (int i = 0; i < n && i < fq.size(); i++) chk({tag, "_fifo_entry"}, 32'(fq[i]), 32'(b[i]));
  endtask
  task automatic scan_check(input string name, input int row, input logic [15:0] val);
    int k = 0;
    while (32'(scan_row) != row && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) begin
      checks++;
      errors++;
      $display("FAIL %s row %0d never scanned, want %h", name, row, val);
    end else chk(name, 32'(scan_data), 32'(val));
  endtask
  initial begin
    logic [7:0] b [$];
    for (int i = 0; i < 8; i++) m_disp[i] = 16'd0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {busy, frame_done, collision, fifo_rdreq, fifo_wrreq, fifo_data, scan_row, scan_data}, 32'd0);
    reset = 1'b0;
    cmp_en = 1'b1;
    b = '{8'h32, 8'h42, 8'h52};
    run_frame("body3", b, 4'd10, 4'd6, 1'b0);
    scan_check("body3_row2", 2, 16'h0038);
    scan_check("body3_row6", 6, 16'h0400);
    b = '{8'h11, 8'h21, 8'h11};
    run_frame("dup", b, 4'd0, 4'd8, 1'b0);
    chk("dup_collision_lit", 32'(collision), 32'd1);
    scan_check("dup_row1", 1, 16'h0006);
    b.delete();
    for (int i = 0; i < 16; i++) b.push_back({4'(i), (i == 5) ? 4'd9 : 4'(i % 8)});
    run_frame("full", b, 4'd0, 4'd8, 1'b0);
    scan_check("full_row5", 5, 16'h2000);
    scan_check("full_row0", 0, 16'h0101);
    b = '{8'h70};
    run_frame("spam", b, 4'd1, 4'd0, 1'b1);
    scan_check("spam_row0", 0, 16'h0082);
    b = '{8'h13, 8'h23, 8'h33, 8'h43, 8'h53};
    load(b, 4'd2, 4'd2);
    frame_req = 1'b1;
    @(posedge clk) m_busy = 1'b1;
    @(negedge clk) frame_req = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("midread_rdreq", 32'(fifo_rdreq), 32'd1);
    cmp_en = 1'b0;
    reset = 1'b1;
    m_busy = 1'b0;
    for (int i = 0; i < 8; i++) m_disp[i] = 16'd0;
    @(posedge clk);
    #1;
    chk("midread_reset_outs", {busy, frame_done, collision, fifo_rdreq, fifo_wrreq, fifo_data, scan_row, scan_data}, 32'd0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk) cmp_en = 1'b1;
    b.delete();
    run_frame("empty", b, 4'd0, 4'd0, 1'b0);
    scan_check("empty_row0", 0, 16'h0001);
    scan_check("empty_row3", 3, 16'h0000);
    repeat (34) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
